irq_ctrl: RTL and testbench
===========================

# irq_ctrl

Memory-mapped interrupt controller between the peripheral IRQ lines (timer/counter IRQs and external sources) and the CPU's CP0 exception logic. It latches each source as edge- or level-sensitive, applies a mask, and picks the highest-priority pending source. It then drives a single registered interrupt request with an acknowledge / end-of-interrupt handshake, so only one source is in service at a time. It sits on the system bridge next to the timers as a 4-word register window.

## Interface

- N, 6, number of interrupt sources, legal range 1..8; index 0 has the highest priority.

- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset; while low, all state is held at its reset values.
- src  input  N  raw interrupt lines from the peripherals (same clock domain, e.g. TC IRQ).
- Addr  input  30  word address [31:2]; only Addr[3:2] is decoded.
- WE  input  1  register write strobe, sampled at the clock edge.
- Din  input  32  register write data.
- Dout  output  32  register read data; combinational from Addr[3:2].
- ack  input  1  CPU exception-entry acknowledge, 1-cycle pulse.
- irq  output  1  registered interrupt request to CP0.
- vector  output  3  index of the source currently requesting or in service.

## Operation

- Registers, selected by Addr[3:2]; bits N and above read 0 and ignore writes:
  - 0 PENDING: read returns pending[N-1:0]. A write clears each pending bit whose Din bit is 1 (write-1-to-clear); this applies to edge-mode bits only.
  - 1 MASK: read/write. A bit set to 1 enables that source.
  - 2 MODE: read/write. A bit set to 1 makes the source edge-sensitive; 0 makes it level-sensitive.
  - 3 STATUS: read returns {valid[31], in_service[30], 27'b0, vector[2:0]}, where valid = |(pending & MASK). Any write is an EOI.
- Pending update on every edge:
  - Level mode: pending[i] <= src[i].
  - Edge mode: pending[i] is set on src[i] & ~src_q[i], where src_q is src registered one cycle.
  - Set wins over a same-cycle W1C write or ack-clear.
- Priority: best = lowest index i with pending[i] & MASK[i].
- State machine:
  - IDLE: irq=0. Go to REQ when any pending & MASK bit is 1.
  - REQ: irq=1; vector = best, re-evaluated every cycle.
    - If ack: go to SERVICE, capture cur <= best, and clear pending[cur] if that source is edge-mode.
    - Else, if pending & MASK becomes 0: go back to IDLE, withdrawing the request.
  - SERVICE: irq=0; vector = cur; in_service=1. A STATUS write (EOI) returns the block to IDLE. New events keep accumulating in PENDING meanwhile; there is no nesting.
- EOI in IDLE or REQ is ignored. ack in IDLE or SERVICE is ignored.
- Reset values: pending=0, MASK=0, MODE=0 (all level), src_q=0, cur=0, state=IDLE, irq=0, vector=0. Dout then reads 0 at every address.
- Reset asserted mid-operation, including in SERVICE, returns everything to these values immediately. No EOI is needed afterwards.

## Timing

- A src rising edge sampled at edge t sets pending after t. State becomes REQ at t+1, so irq is high from the cycle after t+1: a 2-edge latency.
- Register writes take effect at the sampling edge. A MASK write that clears the last enabled pending source drops irq one cycle later (REQ→IDLE).
- ack sampled at edge t drops irq after t. A new request cannot be raised before the edge following an EOI, so the minimum gap is 1 cycle in IDLE.
- Switching a source from edge to level mode makes its pending bit follow src from the next edge.
- A level-mode source stays pending until the peripheral deasserts src. After EOI, a still-high level source re-requests two edges later.

## Test plan

- Reset: hold reset low, toggle src and WE → irq=0, Dout=0 at all 4 addresses. Release reset → still 0 until MASK is written.
- Edge source: MODE=0x01, MASK=0x01, pulse src[0] for 1 cycle → irq high 2 edges later, vector=0. ack → irq=0, PENDING=0, STATUS=0x4000_0000. EOI write → state IDLE, irq stays 0.
- Priority: MASK=0x3F, level src=0b100100 → vector=2. Deassert src[2] before ack → vector=5, irq stays 1. Deassert all → irq drops, state IDLE.
- Simultaneous events: edge-mode src[1] rises in the same cycle as a W1C write of 0x02 to PENDING → pending[1]=1. ack in that cycle → pending[1] re-set, and irq reasserts 2 edges after EOI.
- Masked source: src[3] level high with MASK[3]=0 → PENDING=0x08, STATUS valid=0, irq=0. Write MASK=0x08 → irq high 2 edges later.
- Reset mid-service: enter SERVICE, assert reset for 1 cycle → in_service=0, irq=0, MASK=0. With no EOI written, a new request is served after MASK is reprogrammed.

Source files
------------

// File: rtl/irq_ctrl.sv
// irq_ctrl: interrupt controller with per-source edge/level latching,
// masking, fixed priority (index 0 highest) and an ack / EOI handshake.
// Register window (Addr[3:2]): 0 PENDING (W1C), 1 MASK, 2 MODE, 3 STATUS/EOI.
module irq_ctrl #(
   parameter int unsigned N = 6
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [N-1:0]  src,
   input  logic [31:2]   Addr,
   input  logic          WE,
   input  logic [31:0]   Din,
   output logic [31:0]   Dout,
   input  logic          ack,
   output logic          irq,
   output logic [2:0]    vector
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      SERVICE = 2'd2
   } state_t;

   state_t       state, state_nxt;
   logic [N-1:0] pending, pending_nxt;
   logic [N-1:0] mask, mode, src_q;
   logic [N-1:0] enabled, rise, clr;
   logic [2:0]   cur, best;
   logic         any;
   logic         wr_pend, wr_mask, wr_mode, wr_eoi, take;
   logic         unused_bits;

   assign enabled = pending & mask;
   assign any     = |enabled;
   assign rise    = src & ~src_q;

   assign wr_pend = WE && (Addr[3:2] == 2'd0);
   assign wr_mask = WE && (Addr[3:2] == 2'd1);
   assign wr_mode = WE && (Addr[3:2] == 2'd2);
   assign wr_eoi  = WE && (Addr[3:2] == 2'd3);
   assign take    = (state == REQ) && ack;

   assign unused_bits = ^{Addr[31:4], Din[31:N]};

   // Fixed priority: lowest enabled pending index wins.
   always_comb begin
      logic found;
      found = 1'b0;
      best  = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (!found && enabled[i]) begin
            best  = 3'(i);
            found = 1'b1;
         end
      end
   end

   // Next pending: level bits follow src; edge bits set on rise, clear on W1C / ack, set wins.
   always_comb begin
      clr = '0;
      if (wr_pend) clr = Din[N-1:0];
      for (int unsigned i = 0; i < N; i++) begin
         if (take && (best == 3'(i))) clr[i] = 1'b1;
      end
      pending_nxt = (mode & (rise | (pending & ~clr))) | (~mode & src);
   end

   // Request / service state machine transitions.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (any) state_nxt = REQ;
         REQ: begin
            if (ack)       state_nxt = SERVICE;
            else if (!any) state_nxt = IDLE;
         end
         SERVICE: if (wr_eoi) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Vector shows the live winner while requesting and the captured source while in service.
   always_comb begin
      vector = '0;
      case (state)
         REQ:     vector = best;
         SERVICE: vector = cur;
         default: vector = '0;
      endcase
   end

   // Register read mux.
   always_comb begin
      Dout = '0;
      case (Addr[3:2])
         2'd0:    Dout = 32'(pending);
         2'd1:    Dout = 32'(mask);
         2'd2:    Dout = 32'(mode);
         default: Dout = {any, (state == SERVICE), 27'b0, vector};
      endcase
   end

   // Configuration registers, source history and pending latch.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mask    <= '0;
         mode    <= '0;
         src_q   <= '0;
         pending <= '0;
      end else begin
         src_q   <= src;
         pending <= pending_nxt;
         if (wr_mask) mask <= Din[N-1:0];
         if (wr_mode) mode <= Din[N-1:0];
      end
   end

   // State, in-service source capture and registered request output.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         cur   <= '0;
         irq   <= 1'b0;
      end else begin
         state <= state_nxt;
         irq   <= (state_nxt == REQ);
         if (take) cur <= best;
      end
   end

endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed scenarios plus randomized traffic checked against
// a behavioural model of the interrupt controller.
module tb_irq_ctrl;

   localparam int N = 6;
   localparam int PH_IDLE = 0;
   localparam int PH_REQ  = 1;
   localparam int PH_SERV = 2;

   logic          clk;
   logic          reset;
   logic [N-1:0]  src;
   logic [31:2]   Addr;
   logic          WE;
   logic [31:0]   Din;
   logic [31:0]   Dout;
   logic          ack;
   logic          irq;
   logic [2:0]    vector;

   int checks = 0;
   int errors = 0;

   // behavioural model state
   bit [N-1:0] m_pend, m_mask, m_mode, m_srcq;
   int         m_phase;
   int         m_cur;

   irq_ctrl #(.N(N)) dut (
      .clk(clk), .reset(reset), .src(src), .Addr(Addr), .WE(WE), .Din(Din),
      .Dout(Dout), .ack(ack), .irq(irq), .vector(vector)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic int m_best();
      for (int i = 0; i < N; i++)
         if (m_pend[i] && m_mask[i]) return i;
      return 0;
   endfunction

   function automatic bit [2:0] m_vec();
      if (m_phase == PH_REQ)  return 3'(m_best());
      if (m_phase == PH_SERV) return 3'(m_cur);
      return 3'd0;
   endfunction

   function automatic bit [31:0] m_read(input int a);
      bit [31:0] r;
      case (a)
         0: r = 32'(m_pend);
         1: r = 32'(m_mask);
         2: r = 32'(m_mode);
         default: r = {(|(m_pend & m_mask)), (m_phase == PH_SERV), 27'b0, m_vec()};
      endcase
      return r;
   endfunction

   task automatic m_reset();
      m_pend = '0; m_mask = '0; m_mode = '0; m_srcq = '0;
      m_phase = PH_IDLE; m_cur = 0;
   endtask

   task automatic m_step();
      bit [N-1:0] np;
      int  b;
      bit  any_en;
      int  a;
      bit  setb, clrb;
      b      = m_best();
      any_en = |(m_pend & m_mask);
      a      = int'(Addr[3:2]);
      for (int i = 0; i < N; i++) begin
         if (m_mode[i]) begin
            setb  = src[i] && !m_srcq[i];
            clrb  = (WE && a == 0 && Din[i]) || (m_phase == PH_REQ && ack && b == i);
            np[i] = setb || (m_pend[i] && !clrb);
         end else begin
            np[i] = src[i];
         end
      end
      case (m_phase)
         PH_IDLE: if (any_en) m_phase = PH_REQ;
         PH_REQ: begin
            if (ack) begin m_phase = PH_SERV; m_cur = b; end
            else if (!any_en) m_phase = PH_IDLE;
         end
         default: if (WE && a == 3) m_phase = PH_IDLE;
      endcase
      if (WE && a == 1) m_mask = Din[N-1:0];
      if (WE && a == 2) m_mode = Din[N-1:0];
      m_srcq = src;
      m_pend = np;
   endtask

   // advance one clock edge, model follows the DUT inputs present at that edge
   task automatic tick();
      if (!reset) m_reset();
      else m_step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input int a, input logic [31:0] d);
      Addr = 30'(a);
      WE   = 1'b1;
      Din  = d;
      tick();
      WE   = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      for (int c = 0; c < 4; c++) begin
         src  = N'($urandom);
         WE   = 1'b1;
         Addr = 30'($urandom);
         Din  = $urandom;
         tick();
      end
      WE = 1'b0;
      checks++;
      if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b want 0", irq); end
      for (int a = 0; a < 4; a++) begin
         Addr = 30'(a);
         #1;
         checks++;
         if (Dout !== 32'h0) begin errors++; $display("FAIL reset_dout[%0d]: got %h want 0", a, Dout); end
      end
      reset = 1'b1;
      for (int c = 0; c < 4; c++) begin
         src = N'($urandom);
         tick();
         checks++;
         if (irq !== 1'b0) begin errors++; $display("FAIL reset_release_irq: got %b want 0", irq); end
      end
      Addr = 30'(1);
      #1;
      checks++;
      if (Dout !== 32'h0) begin errors++; $display("FAIL reset_mask: got %h want 0", Dout); end
      src = '0;
      tick();
   endtask

   task automatic test_edge();
      wr(2, 32'h01);
      wr(1, 32'h01);
      src = 6'b000001;
      tick();
      checks++;
      if (irq !== 1'b0) begin errors++; $display("FAIL edge_t0_irq: got %b want 0", irq); end
      src = '0;
      tick();
      checks++;
      if (irq !== 1'b1 || vector !== 3'd0) begin
         errors++; $display("FAIL edge_req: got irq=%b vec=%0d want irq=1 vec=0", irq, vector);
      end
      ack = 1'b1;
      tick();
      ack = 1'b0;
      checks++;
      if (irq !== 1'b0) begin errors++; $display("FAIL edge_ack_irq: got %b want 0", irq); end
      Addr = 30'(0); #1;
      checks++;
      if (Dout !== 32'h0) begin errors++; $display("FAIL edge_pending: got %h want 0", Dout); end
      Addr = 30'(3); #1;
      checks++;
      if (Dout !== 32'h4000_0000) begin errors++; $display("FAIL edge_status: got %h want 40000000", Dout); end
      wr(3, 32'h0);
      checks++;
      if (irq !== 1'b0 || Dout !== 32'h0) begin
         errors++; $display("FAIL edge_eoi: got irq=%b status=%h want irq=0 status=0", irq, Dout);
      end
   endtask

   task automatic test_priority();
      wr(2, 32'h00);
      wr(1, 32'h3F);
      src = 6'b100100;
      tick();
      tick();
      checks++;
      if (irq !== 1'b1 || vector !== 3'd2) begin
         errors++; $display("FAIL prio_first: got irq=%b vec=%0d want irq=1 vec=2", irq, vector);
      end
      src = 6'b100000;
      tick();
      checks++;
      if (irq !== 1'b1 || vector !== 3'd5) begin
         errors++; $display("FAIL prio_second: got irq=%b vec=%0d want irq=1 vec=5", irq, vector);
      end
      src = '0;
      tick();
      checks++;
      if (irq !== 1'b1) begin errors++; $display("FAIL prio_hold: got %b want 1", irq); end
      tick();
      Addr = 30'(3); #1;
      checks++;
      if (irq !== 1'b0 || Dout !== 32'h0) begin
         errors++; $display("FAIL prio_withdraw: got irq=%b status=%h want irq=0 status=0", irq, Dout);
      end
   endtask

   task automatic test_simultaneous();
      wr(2, 32'h02);
      wr(1, 32'h02);
      src  = 6'b000010;
      Addr = 30'(0);
      WE   = 1'b1;
      Din  = 32'h02;
      tick();
      WE = 1'b0;
      checks++;
      if (Dout !== 32'h02) begin errors++; $display("FAIL simul_w1c: got %h want 00000002", Dout); end
      tick();
      checks++;
      if (irq !== 1'b1 || vector !== 3'd1) begin
         errors++; $display("FAIL simul_req: got irq=%b vec=%0d want irq=1 vec=1", irq, vector);
      end
      src = '0;
      tick();
      src = 6'b000010;
      ack = 1'b1;
      tick();
      ack = 1'b0;
      Addr = 30'(0); #1;
      checks++;
      if (irq !== 1'b0 || Dout !== 32'h02) begin
         errors++; $display("FAIL simul_ack_set: got irq=%b pend=%h want irq=0 pend=00000002", irq, Dout);
      end
      Addr = 30'(3); #1;
      checks++;
      if (Dout !== 32'hC000_0001) begin errors++; $display("FAIL simul_status: got %h want c0000001", Dout); end
      wr(3, 32'h0);
      checks++;
      if (irq !== 1'b0) begin errors++; $display("FAIL simul_eoi: got %b want 0", irq); end
      tick();
      checks++;
      if (irq !== 1'b1) begin errors++; $display("FAIL simul_rereq: got %b want 1", irq); end
      ack = 1'b1;
      tick();
      ack = 1'b0;
      src = '0;
      wr(3, 32'h0);
      tick();
   endtask

   task automatic test_masked();
      wr(1, 32'h00);
      wr(2, 32'h00);
      src = 6'b001000;
      tick();
      tick();
      Addr = 30'(0); #1;
      checks++;
      if (Dout !== 32'h08) begin errors++; $display("FAIL masked_pending: got %h want 00000008", Dout); end
      Addr = 30'(3); #1;
      checks++;
      if (Dout !== 32'h0 || irq !== 1'b0) begin
         errors++; $display("FAIL masked_status: got status=%h irq=%b want 0 0", Dout, irq);
      end
      wr(1, 32'h08);
      checks++;
      if (irq !== 1'b0) begin errors++; $display("FAIL masked_t0: got %b want 0", irq); end
      tick();
      checks++;
      if (irq !== 1'b1 || vector !== 3'd3) begin
         errors++; $display("FAIL masked_req: got irq=%b vec=%0d want irq=1 vec=3", irq, vector);
      end
      ack = 1'b1;
      tick();
      ack = 1'b0;
      src = '0;
      wr(3, 32'h0);
      tick();
   endtask

   task automatic test_reset_mid_service();
      src = 6'b010000;
      wr(1, 32'h10);
      tick();
      ack = 1'b1;
      tick();
      ack = 1'b0;
      Addr = 30'(3); #1;
      checks++;
      if (Dout !== 32'hC000_0004) begin errors++; $display("FAIL rst_svc_status: got %h want c0000004", Dout); end
      reset = 1'b0;
      #1;
      checks++;
      if (Dout !== 32'h0 || irq !== 1'b0) begin
         errors++; $display("FAIL rst_svc_async: got status=%h irq=%b want 0 0", Dout, irq);
      end
      Addr = 30'(1); #1;
      checks++;
      if (Dout !== 32'h0) begin errors++; $display("FAIL rst_svc_mask: got %h want 0", Dout); end
      tick();
      reset = 1'b1;
      tick();
      checks++;
      if (irq !== 1'b0) begin errors++; $display("FAIL rst_svc_idle: got %b want 0", irq); end
      wr(1, 32'h10);
      tick();
      checks++;
      if (irq !== 1'b1 || vector !== 3'd4) begin
         errors++; $display("FAIL rst_svc_rereq: got irq=%b vec=%0d want irq=1 vec=4", irq, vector);
      end
      ack = 1'b1;
      tick();
      ack = 1'b0;
      Addr = 30'(3); #1;
      checks++;
      if (Dout !== 32'hC000_0004) begin errors++; $display("FAIL rst_svc_serve: got %h want c0000004", Dout); end
      src = '0;
      wr(3, 32'h0);
      tick();
   endtask

   task automatic test_random();
      bit [31:0] exp_d;
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 99) < 30) src = N'($urandom);
         WE   = ($urandom_range(0, 99) < 20);
         Addr = 30'($urandom);
         Din  = $urandom;
         ack  = ($urandom_range(0, 99) < 15);
         reset = ($urandom_range(0, 999) < 5) ? 1'b0 : 1'b1;
         tick();
         exp_d = m_read(int'(Addr[3:2]));
         checks++;
         if (irq !== (m_phase == PH_REQ) || vector !== m_vec() || Dout !== exp_d) begin
            errors++;
            $display("FAIL random[%0d]: got irq=%b vec=%0d dout=%h want irq=%b vec=%0d dout=%h",
                     c, irq, vector, Dout, (m_phase == PH_REQ), m_vec(), exp_d);
         end
      end
      reset = 1'b1;
      WE    = 1'b0;
      ack   = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      src   = '0;
      Addr  = '0;
      WE    = 1'b0;
      Din   = '0;
      ack   = 1'b0;
      m_reset();
      #1;
      test_reset();
      test_edge();
      test_priority();
      test_simultaneous();
      test_masked();
      test_reset_mid_service();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
